// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared definitions for the write-back/commit stage:
// CSR map, trap causes, mstatus bit positions, state encoding, LSU->WBU bus.
package ysyx_25020037_wbu_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
    localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
    localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    typedef struct packed {
        logic [3:0]  rd;
        logic        ecall_en;
        logic        mret_en;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic        gpr_we;
        logic        is_read;
        logic [31:0] csr_wdata;
        logic [31:0] result;
    } lsu_wbu_t;

    // Trap vector and return address registers are word aligned.
    function automatic logic [31:0] align4(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25020037_regfile.sv
// RV32E general purpose register file: 2 combinational read ports,
// 1 write port, x0 hardwired to zero.
module ysyx_25020037_regfile #(
    parameter int NR_GPR = 16,
    parameter int AW     = $clog2(NR_GPR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [31:0]   rdata1_o,
    output logic [31:0]   rdata2_o
);

    logic [31:0] regs_q [NR_GPR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_GPR; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back/commit stage: GPR and M-mode CSR owner, ecall/mret handling.
// Define YSYX_25020037_WBU_FAULT_TRAP_EN to trap on LSU access faults.
module ysyx_25020037_wbu
    import ysyx_25020037_wbu_pkg::*;
#(
    parameter int          NR_GPR        = 16,
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
    parameter logic [31:0] ECALL_CAUSE   = CAUSE_ECALL_M
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        wbu_ready,
    input  logic [3:0]  rd,
    input  logic        gpr_we,
    input  logic [31:0] result,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        ecall_en,
    input  logic        mret_en,
    input  logic [31:0] pc,
    input  logic        access_fault,
    input  logic        is_read,
    input  logic [3:0]  rs1_idx,
    input  logic [3:0]  rs2_idx,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        wbu_valid,
    output logic [31:0] dnpc,
    output logic        redirect
);

    logic [0:0]  state_q, state_d;
    lsu_wbu_t    bus_q, bus_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] dnpc_q, dnpc_d;
    logic        valid_q, valid_d;
    logic        redir_q, redir_d;
    logic        gpr_wen;
    logic        fault_trap;

`ifdef YSYX_25020037_WBU_FAULT_TRAP_EN
    assign fault_trap = fault_q;
`else
    logic unused_fault;
    assign fault_trap   = 1'b0;
    assign unused_fault = fault_q;
`endif

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        dnpc_d    = dnpc_q;
        valid_d   = 1'b0;
        redir_d   = 1'b0;
        gpr_wen   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (lsu_valid) begin
                state_d = ST_COMMIT;
                bus_d   = '{rd:        rd,
                            ecall_en:  ecall_en,
                            mret_en:   mret_en,
                            csr_we:    csr_we,
                            csr_addr:  csr_addr,
                            gpr_we:    gpr_we,
                            is_read:   is_read,
                            csr_wdata: csr_wdata,
                            result:    result};
                pc_d    = pc;
                fault_d = access_fault;
            end
        end else begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            // Priority: ecall > access fault > mret > normal commit.
            if (bus_q.ecall_en || fault_trap) begin
                mepc_d   = pc_q;
                mcause_d = bus_q.ecall_en ? ECALL_CAUSE :
                           bus_q.is_read  ? CAUSE_LOAD_FAULT :
                                            CAUSE_STORE_FAULT;
                mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
                mstatus_d[MSTATUS_MIE]  = 1'b0;
                dnpc_d  = mtvec_q;
                redir_d = 1'b1;
            end else if (bus_q.mret_en) begin
                mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
                mstatus_d[MSTATUS_MPIE] = 1'b1;
                dnpc_d  = mepc_q;
                redir_d = 1'b1;
            end else begin
                gpr_wen = bus_q.gpr_we && (bus_q.rd != '0);
                if (bus_q.csr_we) begin
                    case (bus_q.csr_addr)
                        CSR_MSTATUS: mstatus_d = bus_q.csr_wdata;
                        CSR_MTVEC:   mtvec_d   = align4(bus_q.csr_wdata);
                        CSR_MEPC:    mepc_d    = align4(bus_q.csr_wdata);
                        CSR_MCAUSE:  mcause_d  = bus_q.csr_wdata;
                        default:     ;
                    endcase
                end
                dnpc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bus_q     <= '0;
            pc_q      <= '0;
            fault_q   <= 1'b0;
            mstatus_q <= RESET_MSTATUS;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            dnpc_q    <= '0;
            valid_q   <= 1'b0;
            redir_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            pc_q      <= pc_d;
            fault_q   <= fault_d;
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            dnpc_q    <= dnpc_d;
            valid_q   <= valid_d;
            redir_q   <= redir_d;
        end
    end

    ysyx_25020037_regfile #(
        .NR_GPR (NR_GPR)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (gpr_wen),
        .waddr_i  (bus_q.rd),
        .wdata_i  (bus_q.result),
        .raddr1_i (rs1_idx),
        .raddr2_i (rs2_idx),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    always_comb begin
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = mstatus_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            default:     csr_rdata = '0;
        endcase
    end

    assign wbu_ready = (state_q == ST_IDLE);
    assign wbu_valid = valid_q;
    assign dnpc      = dnpc_q;
    assign redirect  = redir_q;

endmodule

// File: doc/ysyx_25020037_wbu.md
Name: ysyx_25020037_wbu

Overview:
Write-back/commit stage directly downstream of the LSU.
- Consumes the LSU result stream via a valid/ready handshake.
- Owns the RV32E GPR file (x0–x15) and the machine-mode CSR file.
- Commits register and CSR writes, takes ecall traps and executes mret.
- Emits a one-cycle commit pulse carrying the next PC to the IFU.

Parameters:
- NR_GPR, 16: number of architectural GPRs; the rd index width is 4.
- RESET_MSTATUS, 32'h0000_1800: mstatus reset value (MPP = M-mode).
- ECALL_CAUSE, 32'd11: mcause value written by ecall from M-mode.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- lsu_valid  in  1  LSU result valid
- wbu_ready  out  1  WBU can accept a result
- rd  in  4  destination GPR
- gpr_we  in  1  GPR write enable
- result  in  32  value to write to rd (ALU result, loaded data, or old CSR value)
- csr_we  in  1  CSR write enable
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- ecall_en  in  1  instruction is ecall
- mret_en  in  1  instruction is mret
- pc  in  32  PC of the committing instruction
- access_fault  in  1  LSU bus error (used only with the optional feature)
- is_read  in  1  instruction was a load
- rs1_idx, rs2_idx  in  4 each  IDU read addresses
- rs1_data, rs2_data  out  32 each  combinational GPR reads; x0 reads 0
- csr_raddr  in  12  IDU CSR read address
- csr_rdata  out  32  combinational CSR read; unmapped addresses read 0
- wbu_valid  out  1  commit pulse to IFU
- dnpc  out  32  next PC; valid only while wbu_valid is 1
- redirect  out  1  dnpc is a trap or mret target rather than pc+4

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values:
  - all GPRs 0; mstatus = RESET_MSTATUS; mtvec, mepc, mcause 0
  - wbu_valid 0, dnpc 0, redirect 0; state IDLE
- States:
  - IDLE: wbu_ready = 1. If lsu_valid, latch all input fields and go to COMMIT.
  - COMMIT: wbu_ready = 0. Perform the commit (below), assert wbu_valid, return to IDLE.
- Latency: 2 cycles from accepted lsu_valid to the wbu_valid pulse. Back-to-back results are accepted every 2 cycles.
- Commit actions in the COMMIT cycle, applied on the clock edge that enters IDLE (latched values):
  - ecall_en:
    - mepc <= pc; mcause <= ECALL_CAUSE
    - mstatus.MPIE <= mstatus.MIE; mstatus.MIE <= 0
    - dnpc <= mtvec; redirect <= 1; no GPR or CSR-instruction write
  - mret_en:
    - mstatus.MIE <= MPIE; MPIE <= 1
    - dnpc <= mepc; redirect <= 1
  - otherwise:
    - if gpr_we and rd != 0, GPR[rd] <= result; writes to x0 are dropped
    - if csr_we, write the CSR at csr_addr; unmapped addresses are ignored
    - dnpc <= pc + 4 (mod 2^32); redirect <= 0
  - ecall_en and mret_en both set: ecall takes priority.
- Mapped CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - mtvec[1:0] and mepc[1:0] are forced to 0 on write.
- wbu_valid and redirect are one-cycle pulses; both return to 0 in IDLE.
- Read ports: combinational, with no bypass. A read in the commit cycle returns the old value.
- rst mid-COMMIT: the commit is abandoned and all state returns to reset values.
- lsu_valid in COMMIT is ignored; the LSU must hold the result until wbu_ready.

Optional Feature:
Macro: YSYX_25020037_WBU_FAULT_TRAP_EN.
- Defined: a latched access_fault suppresses the GPR write and traps.
  - mepc <= pc; mcause <= 5 if is_read, else 7
  - MIE/MPIE updated as for ecall; dnpc <= mtvec; redirect <= 1
  - priority: ecall > access fault > mret > normal
- Undefined: access_fault is ignored; the commit is normal.

Decomposition:
- Shared package/header holds:
  - CSR address constants, mcause codes, the mstatus MIE/MPIE bit positions
  - the state encoding
- Field order of the LSU-to-WBU bus: rd, ecall_en, mret_en, csr_we, csr_addr, gpr_we, is_read, csr_wdata, result.
- One sub-module: ysyx_25020037_regfile, holding the GPR array, 2 read ports and 1 write port, with x0 hardwired to 0.
- The CSR file stays inline.

Test Plan:
- Reset, then read all GPRs and CSRs -> all 0 except mstatus = 0x1800; wbu_ready = 1.
- lsu_valid with rd=5, gpr_we=1, result=0xDEADBEEF, pc=0x8000_0000:
  - wbu_valid after 2 cycles, dnpc=0x8000_0004, redirect=0
  - rs1_idx=5 reads 0xDEADBEEF afterwards
- rd=0, gpr_we=1, result=0x1234 -> x0 still reads 0.
- csr_we to 0x305 with 0x8000_0103 -> mtvec reads 0x8000_0100.
- ecall at pc=0x8000_0010, mtvec=0x8000_0100:
  - dnpc=0x8000_0100, redirect=1; mepc=0x8000_0010, mcause=11
  - a following mret gives dnpc=0x8000_0010
- Assert rst during COMMIT -> wbu_valid stays 0 and the pending GPR write is not performed.
- With YSYX_25020037_WBU_FAULT_TRAP_EN: load with access_fault=1, rd=3:
  - x3 is unchanged, mcause=5, dnpc=mtvec
  - a store with access_fault=1 gives mcause=7
